// File: rtl/main_memory.sv
// Byte-wide backing store for the cache controller.
// Combinational read, synchronous write, zero-fill after reset.
module main_memory #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Address,
  input  logic [DATA_W-1:0] Data,
  input  logic              ismemWrite,
  output logic [DATA_W-1:0] outputmem,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t state, state_n;

  logic [ADDR_BITS-1:0] ptr, ptr_n;
  logic [ADDR_BITS-1:0] idx, waddr;
  logic [DATA_W-1:0]    wdata;
  logic                 we;
  logic [DATA_W-1:0]    mem [DEPTH];
  logic                 unused_addr;

  assign idx         = Address[ADDR_BITS-1:0];
  assign unused_addr = ^Address[31:ADDR_BITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  // The clear engine and the host share one write port.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    we      = 1'b0;
    waddr   = idx;
    wdata   = Data;
    unique case (state)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = ptr;
        wdata = '0;
        ptr_n = ptr + 1'b1;
        if (&ptr) state_n = S_READY;
      end
      S_READY: we = ismemWrite;
    endcase
    if (rst) we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign ready     = (state == S_READY);
  assign outputmem = ready ? mem[idx] : '0;

endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: stimulus queues expectations,
// a monitor samples the DUT on request and compares.
module tb_main_memory;

  localparam int DEPTH = 4096;

  logic        clk;
  logic        rst;
  logic [31:0] Address;
  logic [7:0]  Data;
  logic        ismemWrite;
  logic [7:0]  outputmem;
  logic        ready;

  main_memory dut (
    .clk       (clk),
    .rst       (rst),
    .Address   (Address),
    .Data      (Data),
    .ismemWrite(ismemWrite),
    .outputmem (outputmem),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    string      name;
    bit         is_rdy;
    logic [7:0] exp;
  } item_t;

  item_t q[$];
  event  ev;
  int    pass_cnt;
  int    total_cnt;

  logic [7:0] ref_mem [DEPTH];
  bit         ref_ready;
  int         clr_cnt;

  initial begin
    item_t      it;
    logic [7:0] act;
    pass_cnt  = 0;
    total_cnt = 0;
    forever begin
      @(ev);
      if (q.size() == 0) begin
        total_cnt++;
        $display("FAIL scoreboard: got sample request, required queued item");
      end else begin
        it  = q.pop_front();
        act = it.is_rdy ? {7'b0, ready} : outputmem;
        total_cnt++;
        if (act === it.exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h (addr %h)",
                      it.name, act, it.exp, Address);
      end
    end
  end

  task automatic expect_data(input string nm, input logic [7:0] e);
    q.push_back('{name: nm, is_rdy: 1'b0, exp: e});
    -> ev;
    #1;
  endtask

  task automatic expect_rdy(input string nm, input logic e);
    q.push_back('{name: nm, is_rdy: 1'b1, exp: {7'b0, e}});
    -> ev;
    #1;
  endtask

  // Reference: a byte array, a cycle count for the clear,
  // writes land only once the memory is usable.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      ref_ready = 1'b0;
      clr_cnt   = 0;
    end else if (!ref_ready) begin
      clr_cnt++;
      if (clr_cnt == DEPTH) begin
        ref_ready = 1'b1;
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      end
    end else if (ismemWrite) begin
      ref_mem[Address[11:0]] = Data;
    end
    @(negedge clk);
  endtask

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_ready ? ref_mem[a[11:0]] : 8'h00;
  endfunction

  initial begin
    logic [31:0] pts [3];
    pts[0] = 32'h000;
    pts[1] = 32'h7ff;
    pts[2] = 32'hfff;
    ref_ready  = 1'b0;
    clr_cnt    = 0;
    rst        = 1'b1;
    ismemWrite = 1'b0;
    Address    = '0;
    Data       = '0;

    step();
    step();
    #1;
    expect_rdy("rst_ready", 1'b0);
    expect_data("rst_out", 8'h00);
    rst = 1'b0;
    repeat (DEPTH - 1) step();
    #1;
    expect_rdy("clr_not_yet", 1'b0);
    step();
    #1;
    expect_rdy("clr_done", 1'b1);
    for (int i = 0; i < 3; i++) begin
      Address = pts[i];
      #1;
      expect_data("clr_zero", 8'h00);
    end

    Address    = 32'h02001f86;
    Data       = 8'h09;
    ismemWrite = 1'b1;
    #1;
    expect_data("rdw_old", 8'h00);
    step();
    ismemWrite = 1'b0;
    #1;
    expect_data("wr_new", 8'h09);
    Address = 32'h00000f86;
    #1;
    expect_data("alias", 8'h09);

    for (int i = 0; i < 8; i++) begin
      Address    = 32'h180 + i;
      Data       = 8'h10 + 8'(i);
      ismemWrite = 1'b1;
      step();
    end
    ismemWrite = 1'b0;
    for (int i = 0; i < 8; i++) begin
      Address = 32'h180 + i;
      #1;
      expect_data("sweep", 8'h10 + 8'(i));
    end
    step();

    Address    = 32'h0abc;
    Data       = 8'h55;
    ismemWrite = 1'b1;
    step();
    Data = 8'hc3;
    step();
    ismemWrite = 1'b0;
    #1;
    expect_data("overwrite", 8'hc3);
    Address = 32'h0abd;
    #1;
    expect_data("ovw_nbr", 8'h00);
    step();

    // Index mask keeps bits 5..7 clear so directed data survives.
    repeat (300) begin
      Address    = $urandom & 32'hffff_f01f;
      ismemWrite = 1'($urandom_range(0, 1));
      Data       = 8'($urandom);
      #1;
      expect_data("rand_rd", ref_rd(Address));
      step();
      ismemWrite = 1'b0;
      #1;
      expect_data("rand_post", ref_rd(Address));
    end

    Address = 32'h0abc;
    rst     = 1'b1;
    step();
    #1;
    expect_rdy("rst2_ready", 1'b0);
    expect_data("rst2_gate", 8'h00);
    rst = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      if (c == 500) begin
        #1;
        expect_data("clear_gate", 8'h00);
      end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 1; c < DEPTH; c++) begin
      if (c >= 10 && c <= 30) begin
        Address    = 32'h0005;
        Data       = 8'haa;
        ismemWrite = 1'b1;
      end else begin
        ismemWrite = 1'b0;
      end
      step();
    end
    ismemWrite = 1'b0;
    #1;
    expect_rdy("mid_not_yet", 1'b0);
    step();
    #1;
    expect_rdy("mid_done", 1'b1);
    Address = 32'h0005;
    #1;
    expect_data("suppress", 8'h00);
    Address = 32'h0abc;
    #1;
    expect_data("recleared", 8'h00);
    Address = 32'h0180;
    #1;
    expect_data("recleared2", 8'h00);

    #5;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/main_memory.md
Name: main_memory

Overview:
- Byte-wide, byte-addressable backing store that sits behind the cache controller and services its line fills and write-backs one byte at a time.
- Writes are synchronous and reads are combinational, so the controller can sweep the 3-bit line offset and sample data in the same cycle.
- A built-in clear engine zero-fills the array after reset.

Parameters:
- ADDR_BITS, 12, number of low address bits decoded; depth = 2^ADDR_BITS bytes (4096 by default).
- DATA_W, 8, data width in bits; fixed at 8 for the cache interface.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Address  input  32  byte address; only Address[ADDR_BITS-1:0] is decoded, upper bits ignored.
- Data  input  8  write data.
- ismemWrite  input  1  write enable, sampled on rising clk.
- outputmem  output  8  read data (combinational).
- ready  output  1  high when the clear sequence is complete and the memory accepts accesses.

Behaviour:
- Storage: 2^ADDR_BITS entries of 8 bits. Index = Address[ADDR_BITS-1:0].
- Aliasing: addresses differing only above bit ADDR_BITS-1 map to the same byte. Example with defaults: 0x02001f86 and 0x00000f86 are the same byte.
- Reset:
  - While rst=1 at a rising edge: clear pointer <= 0, ready <= 0, and the write is ignored.
  - Reset may be asserted at any time, including mid-clear; the clear restarts from entry 0.
- Clear sequence:
  - Starts on the first edge with rst=0 and ready=0.
  - Each edge writes 0x00 to entry[pointer] and increments pointer, so one entry is cleared per cycle.
  - On the edge that clears the last entry (pointer = 2^ADDR_BITS-1), ready <= 1.
  - Total: 2^ADDR_BITS cycles after rst deasserts.
- ready is 0 from the first reset edge until the clear completes, then stays 1 until the next reset.
- Writes:
  - When ready=1, rst=0 and ismemWrite=1 at a rising edge: mem[index] <= Data.
  - When ready=0, ismemWrite is ignored.
- Reads:
  - outputmem = mem[index] combinationally whenever ready=1.
  - outputmem = 0x00 while ready=0.
  - No clock latency: a change of Address is reflected in outputmem in the same cycle.
- Read-during-write: in the cycle a write is issued, outputmem shows the old contents. The new value is visible immediately after the clock edge.
- Back-to-back writes to different addresses on consecutive cycles are all accepted, with no stall.
- Memory contents before the first reset are undefined.
- There are no error conditions; out-of-range upper address bits are silently ignored.

Test Plan:
- Reset and clear: pulse rst for 2 cycles, then release. ready must stay 0 for exactly 4096 edges, then go 1. Afterwards, reads at 0x000, 0x7ff and 0xfff must all return 0x00.
- Basic write/read: after ready, write Data=0x09 to Address=0x02001f86.
  - In the write cycle, outputmem must be 0x00 (old value).
  - On the next cycle, outputmem must be 0x09.
  - Reading 0x00000f86 must also return 0x09 (alias).
- Line sweep: write bytes 0x10..0x17 to addresses 0x0180..0x0187 on 8 consecutive cycles. Then change Address combinationally over 0x0180..0x0187 within one cycle; outputmem must track 0x10..0x17 with no latency.
- Write suppression: with ready=0 during the clear, drive ismemWrite=1, Address=0x0005, Data=0xAA. After ready, Address=0x0005 must read 0x00.
- Reset mid-clear: assert rst for 1 cycle at clear-cycle 1000. After release, ready must rise exactly 4096 cycles later.
- Overwrite: write 0x55 then 0xC3 to Address=0x0abc on consecutive cycles. A read afterwards must return 0xC3, and neighbouring address 0x0abd must remain 0x00.
